// File: rtl/layer1_maxpool.sv
// ============================================================================
// Module      : layer1_maxpool
// Description : CNN layer 1. Applies 2x2 stride-2 max pooling to the
//               IMG_W x IMG_W ReLU map held in the Layer-0 result memory and
//               writes the (IMG_W/2)^2 pooled map to the Layer-1 memory.
//               Optional macro LAYER1_TMR_EN triplicates the max path
//               (2-of-3 vote on cdata_wr1, sticky err on copy disagreement).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer1_maxpool #(
    parameter int IMG_W  = 64,
    parameter int DATA_W = 20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             busy,
    output logic                             crd,
    output logic [2*$clog2(IMG_W)-1:0]       caddr_rd,
    input  logic signed [DATA_W-1:0]         cdata_rd,
    output logic                             cwr1,
    output logic [2*$clog2(IMG_W)-3:0]       caddr_wr1,
    output logic signed [DATA_W-1:0]         cdata_wr1,
    output logic                             Finish1,
    output logic                             err
);

    // Bits per output-map coordinate (row or column of a window).
    localparam int HW  = $clog2(IMG_W) - 1;
    localparam int WAW = 2 * HW;        // window index / write address width
    localparam int RAW = 2 * HW + 2;    // read address width
    localparam logic [WAW-1:0] LAST_K = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAST = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WAW-1:0]   k_q, k_d;
    logic [1:0]       sub_q, sub_d;
    logic             vld_q;            // crd delayed one cycle: cdata_rd is valid
    logic             first_q;          // the valid sample is the first of a window
    logic [RAW-1:0]   caddr_rd_q;
    logic [WAW-1:0]   caddr_wr1_q;
    logic [RAW-1:0]   rd_addr_d;

    // Read address is {row, row-offset, col, col-offset}: doubling the window
    // coordinates and adding 0/1/IMG_W/IMG_W+1 is pure bit placement.
    assign rd_addr_d = {k_d[WAW-1:HW], sub_d[1], k_d[HW-1:0], sub_d[0]};

    // Next-state and strobe decode; busy gates strobes and freezes progress.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sub_d   = sub_q;
        crd     = 1'b0;
        cwr1    = 1'b0;
        Finish1 = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD;
                    k_d     = '0;
                    sub_d   = '0;
                end
            end
            S_RD: begin
                if (!busy) begin
                    crd   = 1'b1;
                    sub_d = sub_q + 2'd1;
                    if (sub_q == 2'd3) begin
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (!busy) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (!busy) begin
                    cwr1 = 1'b1;
                    if (k_q == LAST_K) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + WAW'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_DONE: begin
                Finish1 = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, capture pipe and registered addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            sub_q       <= '0;
            vld_q       <= 1'b0;
            first_q     <= 1'b0;
            caddr_rd_q  <= '0;
            caddr_wr1_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sub_q   <= sub_d;
            vld_q   <= crd;
            first_q <= crd && (sub_q == 2'd0);
            if (state_d == S_RD) begin
                caddr_rd_q <= rd_addr_d;
            end
            if (state_d == S_WR) begin
                caddr_wr1_q <= k_d;
            end
        end
    end

    assign caddr_rd  = caddr_rd_q;
    assign caddr_wr1 = caddr_wr1_q;

    // Running max: first sample of a window loads, later ones replace only
    // when strictly greater (signed).
    function automatic logic signed [DATA_W-1:0] next_max(
        input logic signed [DATA_W-1:0] cur,
        input logic signed [DATA_W-1:0] smp,
        input logic                     first
    );
        return (first || (smp > cur)) ? smp : cur;
    endfunction

`ifdef LAYER1_TMR_EN
    logic signed [DATA_W-1:0] max0_q, max1_q, max2_q;
    logic                     err_q;

    // Three independent max registers, each with its own comparator.
    always_ff @(posedge clk) begin
        if (reset) begin
            max0_q <= '0;
            max1_q <= '0;
            max2_q <= '0;
        end else if (vld_q) begin
            max0_q <= next_max(max0_q, cdata_rd, first_q);
            max1_q <= next_max(max1_q, cdata_rd, first_q);
            max2_q <= next_max(max2_q, cdata_rd, first_q);
        end
    end

    // Sticky disagreement flag, evaluated whenever a write is pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state_q == S_WR) && ((max0_q != max1_q) || (max0_q != max2_q))) begin
            err_q <= 1'b1;
        end
    end

    assign cdata_wr1 = (max0_q & max1_q) | (max0_q & max2_q) | (max1_q & max2_q);
    assign err       = err_q;
`else
    logic signed [DATA_W-1:0] max_q;

    // Single max register.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_q <= '0;
        end else if (vld_q) begin
            max_q <= next_max(max_q, cdata_rd, first_q);
        end
    end

    assign cdata_wr1 = max_q;
    assign err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_layer1_maxpool.sv
// ============================================================================
// Module      : tb_layer1_maxpool
// Description : Directed self-checking bench for layer1_maxpool.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer1_maxpool;

    localparam int DW = 20;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 busy;
    logic                 crd;
    logic [11:0]          caddr_rd;
    logic signed [DW-1:0] cdata_rd;
    logic                 cwr1;
    logic [9:0]           caddr_wr1;
    logic signed [DW-1:0] cdata_wr1;
    logic                 Finish1;
    logic                 err;

    always #5 clk = ~clk;

    layer1_maxpool #(.IMG_W(64), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .cwr1      (cwr1),
        .caddr_wr1 (caddr_wr1),
        .cdata_wr1 (cdata_wr1),
        .Finish1   (Finish1),
        .err       (err)
    );

    // Layer-0 memory model: one-cycle read latency, junk when not reading.
    logic signed [DW-1:0] mem [4096];
    always @(posedge clk) cdata_rd <= crd ? mem[caddr_rd] : 20'sh5A5A5;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Per-run records.
    logic signed [DW-1:0] wr_val  [1024];
    int                   wr_cyc  [1024];
    logic                 wr_seen [1024];
    int   wr_cnt, fin_cyc, fin_pulses, first_crd, busy_viol, err_cyc, err_hi, timed_out, s_edge;
    logic [11:0] first_addr;

    task automatic fill_ramp();
        for (int a = 0; a < 4096; a++) mem[a] = DW'(a);
    endtask

    // Count windows whose written value differs from the ramp-map max
    // (bottom-right sample: 2r*64 + 2c + 65), skipping one window.
    function automatic int ramp_bad(input int skip);
        int bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (k != skip && (!wr_seen[k] || wr_val[k] !== DW'((k >> 5) * 128 + (k & 31) * 2 + 65))) bad++;
        end
        return bad;
    endfunction

    // Pulse start and watch the run cycle by cycle (cycle 1 = first after the
    // start edge). Optional busy window, mid-run reset, stray start, TMR fault.
    task automatic run_pool(input int busy_at, input int busy_len, input int abort_at,
                            input int restart_at, input bit tmr_force);
        int cyc;
        for (int i = 0; i < 1024; i++) begin
            wr_seen[i] = 1'b0; wr_val[i] = '0; wr_cyc[i] = 0;
        end
        wr_cnt = 0; fin_cyc = -1; fin_pulses = 0; first_crd = -1; first_addr = '0;
        busy_viol = 0; err_cyc = -1; err_hi = 0; timed_out = 1;
        @(negedge clk);
        start = 1'b1;
        busy  = 1'b0;
        @(posedge clk);
        #1;
        s_edge = edge_cnt;
        start  = 1'b0;
        for (int n = 0; n < 7000; n++) begin
            @(negedge clk);
            cyc   = edge_cnt - s_edge + 1;
            busy  = (cyc >= busy_at) && (cyc < busy_at + busy_len);
            start = (cyc == restart_at);
`ifdef LAYER1_TMR_EN
            if (tmr_force && cyc == 23) force dut.max1_q = 20'sh12345;
            if (tmr_force && cyc == 25) release dut.max1_q;
`endif
            if (cyc == abort_at) begin
                reset = 1'b1; busy = 1'b0; start = 1'b0; timed_out = 0;
                return;
            end
            #1;
            if (crd && first_crd < 0) begin first_crd = cyc; first_addr = caddr_rd; end
            if (busy && (crd || cwr1)) busy_viol++;
            if (cwr1) begin
                wr_val[caddr_wr1] = cdata_wr1; wr_cyc[caddr_wr1] = cyc; wr_seen[caddr_wr1] = 1'b1; wr_cnt++;
            end
            if (Finish1) begin fin_pulses++; if (fin_cyc < 0) fin_cyc = cyc; end
            if (err) begin err_hi++; if (err_cyc < 0) err_cyc = cyc; end
            if (fin_cyc > 0 && cyc >= fin_cyc + 3) begin timed_out = 0; break; end
        end
        busy  = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        int crd_seen = 0;
        reset = 1'b1;
        repeat (2) begin
            start = 1'($urandom_range(0, 1));
            busy  = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        @(negedge clk); #1;
        chk_cnt++; if (crd !== 1'b0) $display("FAIL rst_crd: got %b want 0", crd); else pass_cnt++;
        chk_cnt++; if (cwr1 !== 1'b0) $display("FAIL rst_cwr1: got %b want 0", cwr1); else pass_cnt++;
        chk_cnt++; if (caddr_rd !== 12'd0) $display("FAIL rst_caddr_rd: got %0d want 0", caddr_rd); else pass_cnt++;
        chk_cnt++; if (caddr_wr1 !== 10'd0) $display("FAIL rst_caddr_wr1: got %0d want 0", caddr_wr1); else pass_cnt++;
        chk_cnt++; if (cdata_wr1 !== 20'd0) $display("FAIL rst_cdata_wr1: got %h want 0", cdata_wr1); else pass_cnt++;
        chk_cnt++; if (Finish1 !== 1'b0) $display("FAIL rst_finish1: got %b want 0", Finish1); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else pass_cnt++;
        reset = 1'b0; start = 1'b0; busy = 1'b0;
        repeat (6) begin @(negedge clk); #1; if (crd) crd_seen++; end
        chk_cnt++; if (crd_seen !== 0) $display("FAIL rst_idle_no_crd: got %0d reads want 0", crd_seen); else pass_cnt++;
    endtask

    task automatic test_ramp();
        fill_ramp();
        run_pool(0, 0, -1, 100, 1'b0);
        chk_cnt++; if (timed_out !== 0) $display("FAIL ramp_timeout: got %0d want 0", timed_out); else pass_cnt++;
        chk_cnt++; if (first_crd !== 1) $display("FAIL ramp_first_crd_cycle: got %0d want 1", first_crd); else pass_cnt++;
        chk_cnt++; if (first_addr !== 12'd0) $display("FAIL ramp_first_addr: got %0d want 0", first_addr); else pass_cnt++;
        chk_cnt++; if (wr_val[0] !== 20'sd65) $display("FAIL ramp_win0: got %0d want 65", wr_val[0]); else pass_cnt++;
        chk_cnt++; if (wr_cyc[0] !== 6) $display("FAIL ramp_win0_cycle: got %0d want 6", wr_cyc[0]); else pass_cnt++;
        chk_cnt++; if (wr_val[1] !== 20'sd67) $display("FAIL ramp_win1: got %0d want 67", wr_val[1]); else pass_cnt++;
        chk_cnt++; if (wr_val[1023] !== 20'sd4095) $display("FAIL ramp_win1023: got %0d want 4095", wr_val[1023]); else pass_cnt++;
        chk_cnt++; if (wr_cyc[1023] !== 6144) $display("FAIL ramp_win1023_cycle: got %0d want 6144", wr_cyc[1023]); else pass_cnt++;
        chk_cnt++; if (fin_cyc !== 6145) $display("FAIL ramp_finish_cycle: got %0d want 6145", fin_cyc); else pass_cnt++;
        chk_cnt++; if (fin_pulses !== 1) $display("FAIL ramp_finish_pulses: got %0d want 1", fin_pulses); else pass_cnt++;
        chk_cnt++; if (wr_cnt !== 1024) $display("FAIL ramp_write_count: got %0d want 1024", wr_cnt); else pass_cnt++;
        chk_cnt++; if (ramp_bad(-1) !== 0) $display("FAIL ramp_all_windows: got %0d bad want 0", ramp_bad(-1)); else pass_cnt++;
        chk_cnt++; if (err_hi !== 0) $display("FAIL ramp_err: got %0d err cycles want 0", err_hi); else pass_cnt++;
    endtask

    task automatic test_signed_max();
        fill_ramp();
        mem[0] = -20'sd5;  mem[1] = -20'sd3;  mem[64] = -20'sd8; mem[65] = -20'sd1;
        mem[2] = 20'sd7;   mem[3] = 20'sd7;   mem[66] = 20'sd7;  mem[67] = 20'sd7;
        mem[4] = 20'sh80000; mem[5] = 20'sh7FFFF; mem[68] = 20'sd0; mem[69] = -20'sd1;
        run_pool(0, 0, -1, -1, 1'b0);
        chk_cnt++; if (timed_out !== 0) $display("FAIL smax_timeout: got %0d want 0", timed_out); else pass_cnt++;
        chk_cnt++; if (wr_val[0] !== 20'hFFFFF) $display("FAIL smax_all_negative: got %h want fffff", wr_val[0]); else pass_cnt++;
        chk_cnt++; if (wr_val[1] !== 20'sd7) $display("FAIL smax_equal: got %h want 00007", wr_val[1]); else pass_cnt++;
        chk_cnt++; if (wr_val[2] !== 20'h7FFFF) $display("FAIL smax_extremes: got %h want 7ffff", wr_val[2]); else pass_cnt++;
        chk_cnt++; if (wr_val[3] !== 20'sd71) $display("FAIL smax_after: got %0d want 71", wr_val[3]); else pass_cnt++;
    endtask

    task automatic test_stall();
        fill_ramp();
        mem[11] = 20'sd1000;   // window 5, second sample: read just before busy rises
        run_pool(33, 3, -1, -1, 1'b0);
        chk_cnt++; if (timed_out !== 0) $display("FAIL stall_timeout: got %0d want 0", timed_out); else pass_cnt++;
        chk_cnt++; if (busy_viol !== 0) $display("FAIL stall_strobe_while_busy: got %0d want 0", busy_viol); else pass_cnt++;
        chk_cnt++; if (wr_val[5] !== 20'sd1000) $display("FAIL stall_win5: got %0d want 1000", wr_val[5]); else pass_cnt++;
        chk_cnt++; if (wr_cyc[5] !== 39) $display("FAIL stall_win5_cycle: got %0d want 39", wr_cyc[5]); else pass_cnt++;
        chk_cnt++; if (ramp_bad(5) !== 0) $display("FAIL stall_other_windows: got %0d bad want 0", ramp_bad(5)); else pass_cnt++;
        chk_cnt++; if (fin_cyc !== 6148) $display("FAIL stall_finish_cycle: got %0d want 6148", fin_cyc); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int late_wr = 0;
        fill_ramp();
        run_pool(0, 0, 63, -1, 1'b0);   // cycle 63 is window 10, third read
        chk_cnt++; if (wr_cnt !== 10) $display("FAIL mid_writes_before: got %0d want 10", wr_cnt); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if ({crd, cwr1, Finish1} !== 3'b000) $display("FAIL mid_strobes: got %b want 000", {crd, cwr1, Finish1}); else pass_cnt++;
        chk_cnt++; if (caddr_rd !== 12'd0) $display("FAIL mid_caddr_rd: got %0d want 0", caddr_rd); else pass_cnt++;
        chk_cnt++; if (caddr_wr1 !== 10'd0) $display("FAIL mid_caddr_wr1: got %0d want 0", caddr_wr1); else pass_cnt++;
        chk_cnt++; if (cdata_wr1 !== 20'd0) $display("FAIL mid_cdata_wr1: got %h want 0", cdata_wr1); else pass_cnt++;
        reset = 1'b0;
        repeat (8) begin @(negedge clk); #1; if (cwr1 || crd) late_wr++; end
        chk_cnt++; if (late_wr !== 0) $display("FAIL mid_no_activity: got %0d want 0", late_wr); else pass_cnt++;
        run_pool(0, 0, -1, -1, 1'b0);
        chk_cnt++; if (first_addr !== 12'd0) $display("FAIL mid_restart_addr: got %0d want 0", first_addr); else pass_cnt++;
        chk_cnt++; if (ramp_bad(-1) !== 0) $display("FAIL mid_restart_windows: got %0d bad want 0", ramp_bad(-1)); else pass_cnt++;
        chk_cnt++; if (fin_cyc !== 6145) $display("FAIL mid_restart_finish: got %0d want 6145", fin_cyc); else pass_cnt++;
    endtask

    task automatic test_tmr();
`ifdef LAYER1_TMR_EN
        fill_ramp();
        run_pool(0, 0, -1, -1, 1'b1);
        chk_cnt++; if (wr_val[3] !== 20'sd71) $display("FAIL tmr_win3_voted: got %h want 71", wr_val[3]); else pass_cnt++;
        chk_cnt++; if (err_cyc !== 25) $display("FAIL tmr_err_rise: got %0d want 25", err_cyc); else pass_cnt++;
        chk_cnt++; if (err_hi !== 6124) $display("FAIL tmr_err_sticky: got %0d want 6124", err_hi); else pass_cnt++;
        chk_cnt++; if (ramp_bad(-1) !== 0) $display("FAIL tmr_all_windows: got %0d bad want 0", ramp_bad(-1)); else pass_cnt++;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        chk_cnt++; if (err !== 1'b0) $display("FAIL tmr_err_cleared: got %b want 0", err); else pass_cnt++;
        reset = 1'b0;
`else
        @(negedge clk); #1;
        chk_cnt++; if (err !== 1'b0) $display("FAIL tmr_err_tied: got %b want 0", err); else pass_cnt++;
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        busy  = 1'b0;
        test_reset();
        test_ramp();
        test_signed_max();
        test_stall();
        test_reset_mid();
        test_tmr();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/layer1_maxpool.md
# layer1_maxpool

Layer 1 of the CNN pipeline. Starts when Layer 0 signals completion, then reads the 64x64 ReLU'd convolution map from the Layer-0 result memory. It applies 2x2, stride-2 max pooling and writes the 32x32 pooled map to the Layer-1 result memory. It sits directly downstream of the Layer-0 zero-pad/convolution/ReLU stage and shares its memory-port style: strobe, address, and 20-bit signed data.

## Interface
Parameters:
- IMG_W, 64, input map width/height; power of two; output map is IMG_W/2 square
- DATA_W, 20, signed fixed-point sample width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse from Layer 0 Finish0; sampled only in IDLE
- busy  in  1  memory-side stall; while high no new crd/cwr1 is issued and the FSM holds
- crd  out  1  Layer-0 memory read strobe
- caddr_rd  out  12  Layer-0 memory read address
- cdata_rd  in  DATA_W  signed read data, valid exactly one cycle after the crd cycle
- cwr1  out  1  Layer-1 memory write strobe
- caddr_wr1  out  10  Layer-1 memory write address
- cdata_wr1  out  DATA_W  signed pooled value
- Finish1  out  1  one-cycle completion pulse
- err  out  1  sticky TMR mismatch flag (see Configuration)

## Operation
- Window index k counts 0..1023, row-major; r = k>>5, c = k&31.
- Base address = (2r)*64 + 2c.
- The four read addresses, in order, are base, base+1, base+64, base+65.
- FSM states: IDLE, RD, LAST, WR, DONE.
  - IDLE -> RD on start.
  - RD spends four non-stalled cycles issuing the four reads, tracked by a 2-bit sub-counter, then -> LAST.
  - LAST captures the fourth sample, then -> WR.
  - WR issues one write. If k = 1023 -> DONE; otherwise k increments and the FSM goes -> RD.
  - DONE asserts Finish1 for one cycle, then -> IDLE.
- Capture: a one-cycle delayed copy of crd marks valid data.
  - The first valid sample of a window loads the max register directly.
  - Each later sample replaces the max only if it is strictly greater under a signed DATA_W compare.
  - Capture is independent of busy.
- cdata_wr1 = max register during WR. caddr_wr1 = k.
- No saturation and no arithmetic. The pooled value is one of the inputs, bit-exact.
- start received outside IDLE is ignored.

## Timing
- Reset (synchronous): FSM -> IDLE; k, the sub-counter and the valid pipe clear. These outputs go to 0: crd, cwr1, caddr_rd, caddr_wr1, cdata_wr1, Finish1, err.
- Reset asserted mid-operation aborts the current window with no partial write. The next start restarts from window 0.
- Per window with no stall: 6 cycles (RD x4, LAST, WR).
- start sampled at edge 0:
  - first crd in cycle 1
  - window 0 written in cycle 6
  - window 1023 written in cycle 6144
  - Finish1 high in cycle 6145
- busy high in RD or WR:
  - crd/cwr1 stay 0 and state and counters hold.
  - A read issued the cycle before busy rose is still captured.
  - Each busy cycle delays completion by exactly one cycle.
- busy in LAST delays only the exit from LAST; the capture still occurs.
- caddr_rd and caddr_wr1 are registered and hold their last values when strobes are low.

## Configuration
- LAYER1_TMR_EN defined:
  - The max register and comparator are triplicated, and cdata_wr1 is the bitwise 2-of-3 majority.
  - err is set in any WR cycle where the copies disagree, and stays set until reset.
- Undefined: a single max path is built and err is tied to 0.
- Data output is identical in both builds when no fault is present.

## Test plan
- Reset: hold reset 2 cycles with random start/busy -> all outputs 0; no crd until a start pulse after reset.
- Ramp map (cdata_rd = address) -> window 0 writes 65 at caddr_wr1 0, window 1 writes 67, window 1023 writes 4095. Finish1 high exactly in cycle 6145 after start.
- Signed max: window 0 samples -5, -3, -8, -1 -> cdata_wr1 = 20'hFFFFF. Equal samples 7, 7, 7, 7 -> 7.
- Stall: busy high 3 cycles during window 5 (RD sub-step 2) -> no strobes while busy, window 5 value unchanged, Finish1 at cycle 6148.
- Reset mid-run at window 10 -> outputs 0 next cycle, no write for window 10. New start -> first read address 0, full correct run.
- With LAYER1_TMR_EN, force one max copy to 20'h12345 during window 3 -> cdata_wr1 correct and err = 1 until reset. Without the macro, err stays 0.
